// File: rtl/serial_pattern_tx_if.sv
// Handshake and serial-output bundle between a word source and serial_pattern_tx.
interface serial_pattern_tx_if #(
   parameter int unsigned WIDTH = 8
);
   logic [WIDTH-1:0] data_in;
   logic             valid_in;
   logic             ready_out;
   logic             w;
   logic             busy;
   logic             done;

   modport master (
      output data_in, valid_in,
      input  ready_out, w, busy, done
   );

   modport slave (
      input  data_in, valid_in,
      output ready_out, w, busy, done
   );
endinterface

// File: rtl/serial_pattern_tx.sv
// MSB-first parallel-to-serial pattern transmitter with forced-low gap and done pulse.
// Define SERIAL_TX_PARITY_EN to append one even-parity bit after the data bits.
module serial_pattern_tx #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned GAP   = 1
) (
   input  logic               clk,
   input  logic               reset,
   serial_pattern_tx_if.slave tx
);
   localparam int unsigned      CNT_W    = $clog2(WIDTH);
   localparam int unsigned      GAP_W    = 4;
   localparam logic [CNT_W-1:0] BIT_LOAD = CNT_W'(WIDTH - 1);
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP > 0) ? (GAP - 1) : 0);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SHIFT  = 2'd1,
      S_GAP    = 2'd2
`ifdef SERIAL_TX_PARITY_EN
      , S_PARITY = 2'd3
`endif
   } state_t;

   localparam state_t S_POST = (GAP > 0) ? S_GAP : S_IDLE;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_shift;
   logic [CNT_W-1:0] r_bit_cnt;
   logic [GAP_W-1:0] r_gap_cnt;
   logic             w_ready;
   logic             w_busy;
   logic             w_done;
`ifdef SERIAL_TX_PARITY_EN
   logic             r_parity;
`endif

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (tx.valid_in) w_state_nxt = S_SHIFT;
`ifdef SERIAL_TX_PARITY_EN
         S_SHIFT:  if (r_bit_cnt == '0) w_state_nxt = S_PARITY;
         S_PARITY: w_state_nxt = S_POST;
`else
         S_SHIFT:  if (r_bit_cnt == '0) w_state_nxt = S_POST;
`endif
         S_GAP:    if (r_gap_cnt == '0) w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // Status outputs; done marks the last cycle before returning to IDLE
   always_comb begin
      w_ready = 1'b0;
      w_busy  = 1'b1;
      w_done  = 1'b0;
      if (r_state == S_IDLE) begin
         w_ready = 1'b1;
         w_busy  = 1'b0;
      end else if (w_state_nxt == S_IDLE) begin
         w_done  = 1'b1;
      end
   end

   // Shift register and counters; the MSB of r_shift is the serial bit
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_shift   <= '0;
         r_bit_cnt <= '0;
         r_gap_cnt <= '0;
`ifdef SERIAL_TX_PARITY_EN
         r_parity  <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (tx.valid_in) begin
                  r_shift   <= tx.data_in;
                  r_bit_cnt <= BIT_LOAD;
`ifdef SERIAL_TX_PARITY_EN
                  r_parity  <= ^tx.data_in;
`endif
               end
            end
            S_SHIFT: begin
               r_shift <= {r_shift[WIDTH-2:0], 1'b0};
               if (r_bit_cnt != '0) begin
                  r_bit_cnt <= r_bit_cnt - CNT_W'(1);
               end else begin
                  r_gap_cnt <= GAP_LOAD;
`ifdef SERIAL_TX_PARITY_EN
                  r_shift   <= {r_parity, {(WIDTH-1){1'b0}}};
`endif
               end
            end
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: begin
               r_shift   <= '0;
               r_gap_cnt <= GAP_LOAD;
            end
`endif
            S_GAP: begin
               if (r_gap_cnt != '0) r_gap_cnt <= r_gap_cnt - GAP_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign tx.ready_out = w_ready;
   assign tx.busy      = w_busy;
   assign tx.done      = w_done;
   assign tx.w         = r_shift[WIDTH-1];
endmodule
